// File: rtl/sys_gatherer.sv
// Width up-converter: packs Depth consecutive LanesIn-lane beats into one wide word,
// aligning frames on in_start. The first beat lands in the highest lanes.
module sys_gatherer #(
    parameter int BitSize = 8,
    parameter int LanesIn = 2,
    parameter int Depth   = 2
) (
    input  logic                                    clk,
    input  logic                                    res_n,
    input  logic                                    in_valid,
    input  logic                                    in_start,
    input  logic [LanesIn-1:0][BitSize-1:0]         in_data,
    output logic                                    out_valid,
    output logic                                    out_start,
    output logic [LanesIn*Depth-1:0][BitSize-1:0]   out_data,
    output logic                                    out_drop
);

    localparam int NumOfNerves = LanesIn * Depth;
    localparam int CntW        = $clog2(Depth) + 1;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                               state_q, state_d;
    logic [CntW-1:0]                      cnt_q, cnt_d;
    logic                                 first_q, first_d;
    logic [NumOfNerves-1:0][BitSize-1:0]  buf_q, buf_d;
    logic [NumOfNerves-1:0][BitSize-1:0]  data_q, data_d;
    logic                                 valid_q, valid_d;
    logic                                 start_q, start_d;
    logic                                 drop_q, drop_d;

    logic                                 accept;
    logic [CntW-1:0]                      beat_idx;
    logic                                 first_now;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        buf_d     = buf_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        start_d   = 1'b0;
        drop_d    = 1'b0;
        accept    = in_valid && (in_start || (state_q == COLLECT));
        beat_idx  = in_start ? '0 : cnt_q;
        first_now = in_start || first_q;

        if (in_valid && !accept) begin
            drop_d = 1'b1;
        end

        if (accept) begin
            // A start while a partial word is pending throws that partial word away.
            if (in_start && (state_q == COLLECT) && (cnt_q != '0)) begin
                drop_d = 1'b1;
            end
            state_d = COLLECT;
            for (int unsigned b = 0; b < Depth; b++) begin
                if (beat_idx == CntW'(b)) begin
                    for (int unsigned l = 0; l < LanesIn; l++) begin
                        buf_d[(Depth - 1 - b) * LanesIn + l] = in_data[l];
                    end
                end
            end
            // The completed word is copied out so assembly of the next one can start at once.
            if (beat_idx == CntW'(Depth - 1)) begin
                valid_d = 1'b1;
                start_d = first_now;
                data_d  = buf_d;
                first_d = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d   = beat_idx + CntW'(1);
                first_d = first_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            buf_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= start_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_start = start_q;
    assign out_data  = data_q;
    assign out_drop  = drop_q;

endmodule

// File: tb/tb_sys_gatherer.sv
// Bench for sys_gatherer: a queue-based frame model checked every cycle, plus directed
// literal checks. Instance a: LanesIn=2, Depth=2. Instance b: LanesIn=4, Depth=1.
module tb_sys_gatherer;

    localparam int LA = 2;
    localparam int DA = 2;
    localparam int LB = 4;
    localparam int DB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rn_a, iv_a, is_a;
    logic [LA-1:0][7:0]   d_a;
    logic                 ov_a, os_a, od_a;
    logic [LA*DA-1:0][7:0] odat_a;

    logic                 rn_b, iv_b, is_b;
    logic [LB-1:0][7:0]   d_b;
    logic                 ov_b, os_b, od_b;
    logic [LB*DB-1:0][7:0] odat_b;

    sys_gatherer #(.BitSize(8), .LanesIn(LA), .Depth(DA)) dut_a (
        .clk(clk), .res_n(rn_a), .in_valid(iv_a), .in_start(is_a), .in_data(d_a),
        .out_valid(ov_a), .out_start(os_a), .out_data(odat_a), .out_drop(od_a)
    );

    sys_gatherer #(.BitSize(8), .LanesIn(LB), .Depth(DB)) dut_b (
        .clk(clk), .res_n(rn_b), .in_valid(iv_b), .in_start(is_b), .in_data(d_b),
        .out_valid(ov_b), .out_start(os_b), .out_data(odat_b), .out_drop(od_b)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame model: beats of an open frame are queued lane by lane (highest lane first);
    // a full queue becomes the expected word.
    logic [7:0]            qa[$];
    logic [7:0]            qb[$];
    bit                    open_a, first_a, ev_a, es_a, ed_a;
    bit                    open_b, first_b, ev_b, es_b, ed_b;
    logic [LA*DA-1:0][7:0] edat_a;
    logic [LB*DB-1:0][7:0] edat_b;

    initial forever begin
        @(posedge clk);
        ev_a = 0; es_a = 0; ed_a = 0;
        if (!rn_a) begin
            open_a = 0; first_a = 0; qa.delete(); edat_a = '0;
        end else if (iv_a) begin
            if (is_a) begin
                if (qa.size() != 0) ed_a = 1;
                qa.delete(); open_a = 1; first_a = 1;
            end
            if (!open_a) ed_a = 1;
            else begin
                for (int l = LA - 1; l >= 0; l--) qa.push_back(d_a[l]);
                if (qa.size() == LA * DA) begin
                    ev_a = 1; es_a = first_a; first_a = 0;
                    for (int i = 0; i < LA * DA; i++) edat_a[LA*DA-1-i] = qa[i];
                    qa.delete();
                end
            end
        end
        ev_b = 0; es_b = 0; ed_b = 0;
        if (!rn_b) begin
            open_b = 0; first_b = 0; qb.delete(); edat_b = '0;
        end else if (iv_b) begin
            if (is_b) begin
                if (qb.size() != 0) ed_b = 1;
                qb.delete(); open_b = 1; first_b = 1;
            end
            if (!open_b) ed_b = 1;
            else begin
                for (int l = LB - 1; l >= 0; l--) qb.push_back(d_b[l]);
                if (qb.size() == LB * DB) begin
                    ev_b = 1; es_b = first_b; first_b = 0;
                    for (int i = 0; i < LB * DB; i++) edat_b[LB*DB-1-i] = qb[i];
                    qb.delete();
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("a_valid", 32'(ov_a), 32'(ev_a));
            check("a_start", 32'(os_a & ov_a), 32'(es_a));
            check("a_drop",  32'(od_a), 32'(ed_a));
            check("a_data",  32'(odat_a), 32'(edat_a));
            check("b_valid", 32'(ov_b), 32'(ev_b));
            check("b_start", 32'(os_b & ov_b), 32'(es_b));
            check("b_drop",  32'(od_b), 32'(ed_b));
            check("b_data",  32'(odat_b), 32'(edat_b));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic beat_a(input bit s, input logic [15:0] d);
        iv_a = 1'b1; is_a = s; d_a = d;
        tick();
        iv_a = 1'b0; is_a = 1'b0;
    endtask

    task automatic beat_b(input bit s, input logic [31:0] d);
        iv_b = 1'b1; is_b = s; d_b = d;
        tick();
        iv_b = 1'b0; is_b = 1'b0;
    endtask

    task automatic lit_a(input string n, input bit v, input bit s, input bit dr, input logic [31:0] d);
        check({n, "_valid"}, 32'(ov_a), 32'(v));
        check({n, "_start"}, 32'(os_a), 32'(s));
        check({n, "_drop"},  32'(od_a), 32'(dr));
        check({n, "_data"},  32'(odat_a), d);
    endtask

    task automatic lit_b(input string n, input bit v, input bit s, input bit dr, input logic [31:0] d);
        check({n, "_valid"}, 32'(ov_b), 32'(v));
        check({n, "_start"}, 32'(os_b), 32'(s));
        check({n, "_drop"},  32'(od_b), 32'(dr));
        check({n, "_data"},  32'(odat_b), d);
    endtask

    initial begin
        rn_a = 1'b0; rn_b = 1'b0;
        iv_a = 1'b0; is_a = 1'b0; d_a = '0;
        iv_b = 1'b0; is_b = 1'b0; d_b = '0;
        repeat (3) begin
            iv_a = 1'($urandom); is_a = 1'($urandom); d_a = 16'($urandom);
            iv_b = 1'($urandom); is_b = 1'($urandom); d_b = $urandom;
            tick();
            chk_en = 1'b1;
        end
        lit_a("rst_a", 0, 0, 0, 32'h0);
        lit_b("rst_b", 0, 0, 0, 32'h0);
        rn_a = 1'b1; rn_b = 1'b1;
        iv_a = 1'b0; is_a = 1'b0; iv_b = 1'b0; is_b = 1'b0;
        tick();

        // beats before any frame start are dropped
        for (int i = 0; i < 3; i++) begin
            beat_a(0, 16'($urandom));
            lit_a("preframe", 0, 0, 1, 32'h0);
        end

        // two back-to-back words of one frame
        beat_a(1, 16'h0102);
        lit_a("frame_b0", 0, 0, 0, 32'h0);
        beat_a(0, 16'h0304);
        lit_a("frame_w0", 1, 1, 0, 32'h01020304);
        beat_a(0, 16'h0506);
        lit_a("frame_b2", 0, 0, 0, 32'h01020304);
        beat_a(0, 16'h0708);
        lit_a("frame_w1", 1, 0, 0, 32'h05060708);

        // realign discards the pending partial word
        beat_a(1, 16'h0A0A);
        lit_a("realign_a", 0, 0, 0, 32'h05060708);
        beat_a(1, 16'h1112);
        lit_a("realign_drop", 0, 0, 1, 32'h05060708);
        beat_a(0, 16'h1314);
        lit_a("realign_w", 1, 1, 0, 32'h11121314);

        // idle gaps inside a word
        beat_a(1, 16'h2122);
        repeat (5) tick();
        lit_a("gap_wait", 0, 0, 0, 32'h11121314);
        beat_a(0, 16'h2324);
        lit_a("gap_w", 1, 1, 0, 32'h21222324);
        tick();
        lit_a("gap_hold", 0, 0, 0, 32'h21222324);

        // reset mid-word: partial discarded silently, frame closed afterwards
        beat_a(1, 16'h3132);
        rn_a = 1'b0;
        tick();
        rn_a = 1'b1;
        lit_a("midrst", 0, 0, 0, 32'h0);
        beat_a(0, 16'h3334);
        lit_a("midrst_drop", 0, 0, 1, 32'h0);
        beat_a(1, 16'h4142);
        beat_a(0, 16'h4344);
        lit_a("midrst_w", 1, 1, 0, 32'h41424344);

        // Depth=1, four lanes
        beat_b(1, 32'h11223344);
        lit_b("d1_w0", 1, 1, 0, 32'h11223344);
        beat_b(0, 32'hAABBCCDD);
        lit_b("d1_w1", 1, 0, 0, 32'hAABBCCDD);
        beat_b(1, 32'h01020304);
        lit_b("d1_w2", 1, 1, 0, 32'h01020304);
        rn_b = 1'b0;
        iv_b = 1'b1; is_b = 1'b1; d_b = 32'h99999999;
        tick();
        rn_b = 1'b1; iv_b = 1'b0; is_b = 1'b0;
        lit_b("d1_rst", 0, 0, 0, 32'h0);
        beat_b(0, 32'h55667788);
        lit_b("d1_drop", 0, 0, 1, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
